usb_uart_tx_arbiter: RTL and testbench

//  Shares the single host-bound uart_in byte pipeline of usb_uart_i40 among N_REQ byte-stream

---
 rtl/usb_uart_tx_arbiter_pkg.sv | 18 +
 rtl/usb_uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/usb_uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_usb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_tx_arbiter_pkg.sv
// Shared constants for the usb_uart transmit-side arbiter: EOL byte, FSM encodings
// and the default idle timeout derived from the 48 MHz system clock.
package usb_uart_tx_arbiter_pkg;

  localparam int unsigned CLK_HZ           = 48_000_000;
  localparam int unsigned IDLE_TIMEOUT_US  = 100;
  localparam int unsigned IDLE_TIMEOUT_DEF = (CLK_HZ / 1_000_000) * IDLE_TIMEOUT_US;
  localparam logic [7:0]  EOL_BYTE_DEF     = 8'h0A;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester set, searching upward from the one after 'last'.
module usb_uart_tx_arbiter_rr_pick
  import usb_uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             any,
  output logic [IW-1:0]    winner
);

  assign any = |req;

  // Walk offsets from far to near so the nearest hit after 'last' is the final write.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ])
        winner = IW'((int'(last) + k) % N_REQ);
    end
  end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// Shares the host-bound uart_in byte pipeline among N_REQ requesters; a grant is held
// for a whole message (EOL byte, burst limit or idle timeout) so lines never interleave.
module usb_uart_tx_arbiter
  import usb_uart_tx_arbiter_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter logic [7:0] EOL_BYTE     = EOL_BYTE_DEF
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         uart_in_data,
  output logic               uart_in_valid,
  input  logic               uart_in_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [0:0]             state;
  logic [IW-1:0]          gidx, last;
  logic [BW-1:0]          burst_cnt;
  logic [TW-1:0]          idle_cnt;
  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic [N_REQ-1:0][7:0]  lane_data;
  logic                   beat, release_now;

  usb_uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .last   (last),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // grant is all-zero outside HOLD, so masking by it gives idle outputs for free.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_data[i] = grant[i] ? req_data[8*i +: 8] : 8'h00;
    assign req_ready[i] = grant[i] & uart_in_ready;
  end

  always_comb begin
    uart_in_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) uart_in_data |= lane_data[i];
  end

  assign uart_in_valid = |(grant & req_valid);
  assign busy          = (state == ST_HOLD);
  assign beat          = uart_in_valid & uart_in_ready;

  assign release_now = busy &&
                       ((beat && uart_in_data == EOL_BYTE) ||
                        (beat && burst_cnt == BW'(MAX_BURST - 1)) ||
                        (idle_cnt == TW'(IDLE_TIMEOUT)));

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      gidx      <= '0;
      last      <= IW'(N_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= N_REQ'(1) << pick_idx;
            gidx  <= pick_idx;
            state <= ST_HOLD;
          end
        end
        default: begin
          if (release_now) begin
            state     <= ST_IDLE;
            grant     <= '0;
            last      <= gidx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end else begin
            if (beat && burst_cnt < BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
            // Backpressure alone never counts as idle: only a quiet granted requester does.
            if (uart_in_valid)                       idle_cnt <= '0;
            else if (idle_cnt < TW'(IDLE_TIMEOUT))   idle_cnt <= idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Bench for usb_uart_tx_arbiter: vector table, directed message sequences and random
// traffic, all checked every cycle against a message-level reference model.
module tb_usb_uart_tx_arbiter;
  localparam int         N   = 4;
  localparam int         MB  = 64;
  localparam int         TO  = 10;
  localparam logic [7:0] EOL = 8'h0A;

  logic             clk_48mhz = 1'b0;
  logic             reset = 1'b1;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready, grant;
  logic [7:0]       uart_in_data;
  logic             uart_in_valid, busy;
  logic             uart_in_ready = 1'b0;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO), .EOL_BYTE(EOL)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
    .uart_in_ready(uart_in_ready), .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0] vld; logic [7:0] d0, d1; logic rdy;
    logic [N-1:0] g; logic b, v; logic [7:0] d; logic [N-1:0] r;
  } vec_t;
  vec_t tbl [11];

  int vectors = 0, miscompares = 0, cyc = 0;
  int m_owner, m_last, m_sent, m_quiet;
  logic [7:0] src_q [N][$];
  logic [N-1:0] en;
  int grant_order[$], seg_len[$], gap_len[$], out_src[$];
  logic [7:0] out_byte[$];
  int seg_beats, gap_cnt, drop_cyc, g3_cyc;
  logic prev_busy, seen_seg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r; r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [63:0] dut_out();
    return 64'({busy, uart_in_valid, uart_in_data, req_ready, grant});
  endfunction

  // Model: who owns the link, how much it sent, how long it has been quiet.
  function automatic logic [63:0] model_out();
    logic [N-1:0] g, r; logic v, b; logic [7:0] d;
    g = '0; r = '0; v = 1'b0; d = 8'h00; b = (m_owner >= 0);
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1; r[m_owner] = uart_in_ready;
      v = req_valid[m_owner]; d = req_data[8*m_owner +: 8];
    end
    return 64'({b, v, d, r, g});
  endfunction

  task automatic model_step();
    int w; logic sent_now; logic [7:0] byt;
    if (m_owner < 0) begin
      w = -1;
      for (int k = N; k >= 1; k--) if (req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      m_owner = w;
    end else begin
      sent_now = req_valid[m_owner] && uart_in_ready;
      byt = req_data[8*m_owner +: 8];
      if ((sent_now && byt == EOL) || (sent_now && m_sent + 1 == MB) || m_quiet == TO) begin
        m_last = m_owner; m_owner = -1; m_sent = 0; m_quiet = 0;
      end else begin
        if (sent_now) m_sent++;
        if (req_valid[m_owner]) m_quiet = 0;
        else if (m_quiet < TO) m_quiet++;
      end
    end
  endtask

  task automatic clear_tb();
    en = '0; req_valid = '0; req_data = '0; uart_in_ready = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    grant_order.delete(); seg_len.delete(); gap_len.delete();
    out_byte.delete(); out_src.delete();
    seg_beats = 0; gap_cnt = 0; prev_busy = 1'b0; seen_seg = 1'b0;
    drop_cyc = -1; g3_cyc = -1;
    m_owner = -1; m_last = N - 1; m_sent = 0; m_quiet = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_tb();
    @(posedge clk_48mhz); #1;
    reset = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk_48mhz);
    chk("cycle_outputs", dut_out(), model_out());
    if (busy) begin
      if (!prev_busy) begin
        grant_order.push_back(oh_idx(grant));
        if (seen_seg) gap_len.push_back(gap_cnt);
        seg_beats = 0;
      end
      if (grant == 4'b1000 && g3_cyc < 0) g3_cyc = cyc;
      if (uart_in_valid && uart_in_ready) begin
        seg_beats++; out_byte.push_back(uart_in_data); out_src.push_back(oh_idx(grant));
      end
    end else begin
      if (prev_busy) begin seg_len.push_back(seg_beats); gap_cnt = 0; seen_seg = 1'b1; end
      gap_cnt++;
    end
    prev_busy = busy;
    acc = req_valid & req_ready;
    @(posedge clk_48mhz);
    model_step();
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
  endtask

  task automatic drive_q();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic run_q(input int n);
    for (int c = 0; c < n; c++) begin drive_q(); tick(); end
  endtask

  initial begin
    int line_src; logic line_ok; int nlines;
    tbl[0]  = '{4'b0001, 8'h41, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{4'b0001, 8'h41, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h41, 4'b0001};
    tbl[2]  = '{4'b0001, 8'h42, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h42, 4'b0001};
    tbl[3]  = '{4'b0001, 8'h0A, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h0A, 4'b0001};
    tbl[4]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[5]  = '{4'b0011, 8'h51, 8'h52, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[6]  = '{4'b0011, 8'h51, 8'h52, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h52, 4'b0000};
    tbl[7]  = '{4'b0011, 8'h51, 8'h0A, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h0A, 4'b0010};
    tbl[8]  = '{4'b0001, 8'h51, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[9]  = '{4'b0001, 8'h51, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h51, 4'b0001};
    tbl[10] = '{4'b0001, 8'h0A, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h0A, 4'b0001};

    clear_tb();
    #2;
    chk("reset_state", dut_out(), 64'h0);
    do_reset();

    // "AB\n" from req 0, then arbitration after a release, backpressure, re-grant to 0.
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].vld; req_data = {16'h0, tbl[i].d1, tbl[i].d0};
      uart_in_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl_row%0d", i), dut_out(),
          64'({tbl[i].b, tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].g}));
      tick();
    end

    // All four stream two lines each: round-robin order, lines never interleave.
    do_reset();
    en = 4'b1111; uart_in_ready = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        src_q[i].push_back(8'h30 + 8'(i)); src_q[i].push_back(8'h61 + 8'(k)); src_q[i].push_back(EOL);
      end
    run_q(60);
    chk("t2_grants", grant_order.size(), 8);
    if (grant_order.size() >= 5)
      chk("t2_order", {grant_order[0][7:0], grant_order[1][7:0], grant_order[2][7:0],
                       grant_order[3][7:0], grant_order[4][7:0]}, 40'h00_01_02_03_00);
    line_src = -1; line_ok = 1'b1; nlines = 0;
    for (int j = 0; j < out_byte.size(); j++) begin
      if (line_src < 0) begin
        line_src = out_src[j];
        if (out_byte[j] != 8'h30 + 8'(line_src)) line_ok = 1'b0;
      end else if (out_src[j] != line_src) line_ok = 1'b0;
      if (out_byte[j] == EOL) begin line_src = -1; nlines++; end
    end
    chk("t2_lines_contiguous", {line_ok, 8'(nlines)}, {1'b1, 8'd8});

    // 100 bytes without EOL from req 1: burst release after 64, one idle cycle, remainder.
    do_reset();
    en = 4'b0010; uart_in_ready = 1'b1;
    for (int k = 0; k < 100; k++) src_q[1].push_back(8'h20 + 8'(k % 64));
    run_q(140);
    chk("t3_segments", seg_len.size(), 2);
    if (seg_len.size() == 2) chk("t3_seg_lens", {seg_len[0], seg_len[1]}, {32'd64, 32'd36});
    if (gap_len.size() > 0) chk("t3_gap", gap_len[0], 1);
    chk("t3_total", out_byte.size(), 100);

    // Req 2 sends 3 bytes then goes quiet; waiting req 3 is granted on cycle 12 after the drop.
    do_reset();
    en = 4'b1100; uart_in_ready = 1'b1;
    src_q[2] = '{8'h78, 8'h79, 8'h7A};
    src_q[3] = '{8'h77, EOL};
    for (int c = 0; c < 40; c++) begin
      drive_q(); tick();
      if (src_q[2].size() == 0 && drop_cyc < 0) drop_cyc = cyc;
    end
    chk("t4_timeout_regrant", g3_cyc - drop_cyc, 12);
    chk("t4_req3_bytes", out_byte.size(), 5);

    // Long backpressure never releases; data holds and bytes resume afterwards.
    do_reset();
    en = 4'b0001; uart_in_ready = 1'b1;
    src_q[0] = '{8'h61, 8'h62, EOL};
    run_q(1);
    uart_in_ready = 1'b0;
    run_q(10000);
    chk("t5_held", {busy, uart_in_valid, uart_in_data, grant}, {1'b1, 1'b1, 8'h61, 4'b0001});
    uart_in_ready = 1'b1;
    run_q(8);
    chk("t5_count", out_byte.size(), 3);
    if (out_byte.size() == 3) chk("t5_bytes", {out_byte[0], out_byte[1], out_byte[2]}, 24'h61620A);

    // Async reset mid-burst, after a release that moved the priority pointer to 1.
    do_reset();
    en = 4'b0010; uart_in_ready = 1'b1;
    src_q[1] = '{8'h6B, EOL};
    run_q(6);
    en = 4'b0100;
    for (int k = 0; k < 20; k++) src_q[2].push_back(8'h6D);
    run_q(4);
    chk("t6_pre_reset_grant", grant, 4'b0100);
    #2 reset = 1'b1;
    #1;
    chk("t6_reset_async", {grant, uart_in_valid, req_ready}, 9'h0);
    clear_tb();
    en = 4'b0101; uart_in_ready = 1'b1;
    src_q[0] = '{8'h61, EOL};
    src_q[2] = '{8'h62, EOL};
    reset = 1'b0;
    run_q(2);
    chk("t6_first_winner", grant, 4'b0001);
    run_q(10);

    // Random traffic: EOL-rich, EOL-free dense (burst limit), sparse (timeouts).
    for (int ph = 0; ph < 3; ph++) begin
      int pv, pe;
      pv = (ph == 0) ? 60 : (ph == 1) ? 95 : 15;
      pe = (ph == 0) ? 12 : 0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i] = ($urandom_range(99) < pv);
          req_data[8*i +: 8] = ($urandom_range(99) < pe) ? EOL : 8'($urandom_range(8'hFF, 8'h0B));
        end
        uart_in_ready = ($urandom_range(99) < 80);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
